// File: rtl/gpu_pkg.sv
// Shared GPU framebuffer geometry, default widths and the write-arbiter state encoding.
package gpu_pkg;

  localparam int FB_WIDTH            = 640;
  localparam int FB_HEIGHT           = 480;
  localparam int FBUF_DEPTH_DEF      = FB_WIDTH * FB_HEIGHT;
  localparam int FBUF_ADDR_WIDTH_DEF = 19;
  localparam int FBUF_DATA_WIDTH_DEF = 8;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } fbuf_arb_state_t;

  // Pointer width for an n-way round-robin; a single requester still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fbuf_write_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or after the pointer wins.
module rr_arbiter
  import gpu_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   idx_s;
  logic found_s;

  // Scan requesters in rotated order starting at the pointer.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < N; k++) begin
      idx_s = (int'(ptr) + k) % N;
      if (!found_s && req[idx_s[PW-1:0]]) begin
        grant[idx_s[PW-1:0]] = 1'b1;
        found_s              = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fbuf_write_arbiter.sv
// Framebuffer BRAM write-port owner: round-robin pixel writers plus a priority full-screen clear.
module fbuf_write_arbiter
  import gpu_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int FBUF_ADDR_WIDTH = FBUF_ADDR_WIDTH_DEF,
  parameter int FBUF_DATA_WIDTH = FBUF_DATA_WIDTH_DEF,
  parameter int FBUF_DEPTH      = FBUF_DEPTH_DEF
) (
  input  logic                                 s_axi_ctrl_aclk,
  input  logic                                 s_axi_ctrl_aresetn,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*FBUF_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*FBUF_DATA_WIDTH-1:0]   req_data,
  input  logic                                 clear_start,
  input  logic [FBUF_DATA_WIDTH-1:0]           clear_color,
  output logic                                 clear_busy,
  output logic                                 clear_done,
  input  logic                                 err_clear,
  output logic                                 err_oob,
  output logic                                 fbuf_en_wr,
  output logic                                 fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0]           fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0]           fbuf_data
);

  localparam int                         PW        = ptr_width(NUM_REQ);
  localparam logic [FBUF_ADDR_WIDTH:0]   DEPTH_X   = (FBUF_ADDR_WIDTH + 1)'(FBUF_DEPTH);
  localparam logic [FBUF_ADDR_WIDTH-1:0] LAST_ADDR = FBUF_ADDR_WIDTH'(FBUF_DEPTH - 1);
  localparam logic [PW-1:0]              LAST_IDX  = PW'(NUM_REQ - 1);

  fbuf_arb_state_t              state_r;
  logic [PW-1:0]                ptr_r;
  logic [FBUF_ADDR_WIDTH-1:0]   clr_cnt_r;
  logic [FBUF_DATA_WIDTH-1:0]   clr_color_r;
  logic                         en_r;
  logic [FBUF_ADDR_WIDTH-1:0]   addr_r;
  logic [FBUF_DATA_WIDTH-1:0]   data_r;
  logic                         err_oob_r;
  logic                         clear_done_r;

  logic [NUM_REQ-1:0]           grant_s;
  logic [NUM_REQ-1:0]           req_ready_s;
  logic [NUM_REQ-1:0]           acc_s;
  logic                         acc_any_s;
  logic [PW-1:0]                acc_idx_s;
  logic [FBUF_ADDR_WIDTH-1:0]   acc_addr_s;
  logic [FBUF_DATA_WIDTH-1:0]   acc_data_s;
  logic                         oob_s;
  logic [PW-1:0]                ptr_nxt_s;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  // Grants are only visible while arbitrating; the clear owns the port otherwise.
  always_comb begin
    if (state_r == ARB) begin
      req_ready_s = grant_s;
    end else begin
      req_ready_s = '0;
    end
  end

  // Select the accepted requester's address/data and the next pointer value.
  always_comb begin
    acc_s      = req_valid & req_ready_s;
    acc_any_s  = |acc_s;
    acc_idx_s  = '0;
    acc_addr_s = '0;
    acc_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_s[i]) begin
        acc_idx_s  = PW'(i);
        acc_addr_s = req_addr[i*FBUF_ADDR_WIDTH +: FBUF_ADDR_WIDTH];
        acc_data_s = req_data[i*FBUF_DATA_WIDTH +: FBUF_DATA_WIDTH];
      end else begin
        acc_idx_s = acc_idx_s;
      end
    end
    oob_s = ({1'b0, acc_addr_s} >= DEPTH_X);
    if (acc_idx_s == LAST_IDX) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = acc_idx_s + PW'(1);
    end
  end

  // Arbitration/clear state machine and the registered BRAM port.
  always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
    if (!s_axi_ctrl_aresetn) begin
      state_r      <= ARB;
      ptr_r        <= '0;
      clr_cnt_r    <= '0;
      clr_color_r  <= '0;
      en_r         <= 1'b0;
      addr_r       <= '0;
      data_r       <= '0;
      clear_done_r <= 1'b0;
    end else begin
      en_r         <= 1'b0;
      clear_done_r <= 1'b0;
      case (state_r)
        ARB: begin
          if (acc_any_s) begin
            ptr_r <= ptr_nxt_s;
            // Out-of-range pixels are swallowed: accepted but never written.
            if (!oob_s) begin
              en_r   <= 1'b1;
              addr_r <= acc_addr_s;
              data_r <= acc_data_s;
            end
          end
          if (clear_start) begin
            state_r     <= CLEAR;
            clr_color_r <= clear_color;
            clr_cnt_r   <= '0;
          end
        end
        CLEAR: begin
          en_r   <= 1'b1;
          addr_r <= clr_cnt_r;
          data_r <= clr_color_r;
          if (clr_cnt_r == LAST_ADDR) begin
            state_r      <= ARB;
            clear_done_r <= 1'b1;
            clr_cnt_r    <= '0;
          end else begin
            clr_cnt_r <= clr_cnt_r + FBUF_ADDR_WIDTH'(1);
          end
        end
        default: begin
          state_r <= ARB;
        end
      endcase
    end
  end

  // Sticky out-of-range flag; a new error outranks a simultaneous clear.
  always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
    if (!s_axi_ctrl_aresetn) begin
      err_oob_r <= 1'b0;
    end else if (acc_any_s && oob_s) begin
      err_oob_r <= 1'b1;
    end else if (err_clear) begin
      err_oob_r <= 1'b0;
    end else begin
      err_oob_r <= err_oob_r;
    end
  end

  assign req_ready  = req_ready_s;
  assign clear_busy = (state_r == CLEAR);
  assign clear_done = clear_done_r;
  assign err_oob    = err_oob_r;
  assign fbuf_en_wr = en_r;
  assign fbuf_wrea  = en_r;
  assign fbuf_addr  = addr_r;
  assign fbuf_data  = data_r;

endmodule

// File: tb/tb_fbuf_write_arbiter.sv
// Directed bench for fbuf_write_arbiter, run with a reduced framebuffer depth to keep the clear short.
module tb_fbuf_write_arbiter;

  localparam int NR    = 2;
  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int DEPTH = 4800;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [AW-1:0]     a0 = '0, a1 = '0;
  logic [DW-1:0]     d0 = '0, d1 = '0;
  logic              clear_start = 1'b0;
  logic [DW-1:0]     clear_color = '0;
  logic              clear_busy, clear_done;
  logic              err_clear = 1'b0;
  logic              err_oob;
  logic              fbuf_en_wr, fbuf_wrea;
  logic [AW-1:0]     fbuf_addr;
  logic [DW-1:0]     fbuf_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fbuf_write_arbiter #(
    .NUM_REQ(NR), .FBUF_ADDR_WIDTH(AW), .FBUF_DATA_WIDTH(DW), .FBUF_DEPTH(DEPTH)
  ) dut (
    .s_axi_ctrl_aclk    (clk),
    .s_axi_ctrl_aresetn (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_addr           ({a1, a0}),
    .req_data           ({d1, d0}),
    .clear_start        (clear_start),
    .clear_color        (clear_color),
    .clear_busy         (clear_busy),
    .clear_done         (clear_done),
    .err_clear          (err_clear),
    .err_oob            (err_oob),
    .fbuf_en_wr         (fbuf_en_wr),
    .fbuf_wrea          (fbuf_wrea),
    .fbuf_addr          (fbuf_addr),
    .fbuf_data          (fbuf_data)
  );

  typedef struct {
    logic [1:0]    valid;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          eclr;
    logic [1:0]    x_ready;
    logic          x_en;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_data;
    logic          x_err;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [1:0] v, input int ad0, input int ad1,
                              input int dt0, input int dt1, input logic ec,
                              input logic [1:0] xr, input logic xe, input int xa,
                              input int xd, input logic xerr);
    vec_t r;
    r.valid = v;   r.a0 = AW'(ad0); r.a1 = AW'(ad1);
    r.d0 = DW'(dt0); r.d1 = DW'(dt1); r.eclr = ec;
    r.x_ready = xr; r.x_en = xe; r.x_addr = AW'(xa); r.x_data = DW'(xd); r.x_err = xerr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One table row: drive at the falling edge, check ready, then check the registered port.
  task automatic apply_vec(input vec_t v, input int n);
    @(negedge clk);
    req_valid = v.valid; a0 = v.a0; a1 = v.a1; d0 = v.d0; d1 = v.d1; err_clear = v.eclr;
    #1;
    chk($sformatf("v%0d_ready", n), 32'(req_ready), 32'(v.x_ready));
    @(posedge clk); #1;
    chk($sformatf("v%0d_en", n), 32'({fbuf_en_wr, fbuf_wrea}), 32'({v.x_en, v.x_en}));
    chk($sformatf("v%0d_addr", n), 32'(fbuf_addr), 32'(v.x_addr));
    chk($sformatf("v%0d_data", n), 32'(fbuf_data), 32'(v.x_data));
    chk($sformatf("v%0d_err", n), 32'(err_oob), 32'(v.x_err));
    chk($sformatf("v%0d_clr", n), 32'({clear_busy, clear_done}), 32'd0);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({req_ready, clear_busy, clear_done, err_oob, fbuf_en_wr, fbuf_wrea})
         | 32'(fbuf_addr) | 32'(fbuf_data);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  bad;
    int  found;
    logic last;

    //               valid ad0     ad1    d0     d1    ec    rdy   en  xaddr      xdata  err
    vecs[0]  = mk(2'b01, 'h10,   0,     'hA5,  0,    1'b0, 2'b01, 1'b1, 'h10,     'hA5, 1'b0);
    vecs[1]  = mk(2'b10, 0,      'h20,  0,     'h5A, 1'b0, 2'b10, 1'b1, 'h20,     'h5A, 1'b0);
    vecs[2]  = mk(2'b00, 0,      0,     0,     0,    1'b0, 2'b00, 1'b0, 'h20,     'h5A, 1'b0);
    vecs[3]  = mk(2'b11, 'h100,  'h200, 'h11,  'h22, 1'b0, 2'b01, 1'b1, 'h100,    'h11, 1'b0);
    vecs[4]  = mk(2'b11, 'h101,  'h200, 'h13,  'h22, 1'b0, 2'b10, 1'b1, 'h200,    'h22, 1'b0);
    vecs[5]  = mk(2'b11, 'h101,  'h201, 'h13,  'h24, 1'b0, 2'b01, 1'b1, 'h101,    'h13, 1'b0);
    vecs[6]  = mk(2'b11, 'h102,  'h201, 'h15,  'h24, 1'b0, 2'b10, 1'b1, 'h201,    'h24, 1'b0);
    vecs[7]  = mk(2'b10, 0,      'h30,  0,     'h33, 1'b0, 2'b10, 1'b1, 'h30,     'h33, 1'b0);
    vecs[8]  = mk(2'b01, 'h40,   0,     'h44,  0,    1'b0, 2'b01, 1'b1, 'h40,     'h44, 1'b0);
    vecs[9]  = mk(2'b01, 'h41,   0,     'h45,  0,    1'b0, 2'b01, 1'b1, 'h41,     'h45, 1'b0);
    vecs[10] = mk(2'b01, DEPTH,  0,     'h77,  0,    1'b0, 2'b01, 1'b0, 'h41,     'h45, 1'b1);
    vecs[11] = mk(2'b01, DEPTH-1,0,     'h99,  0,    1'b0, 2'b01, 1'b1, DEPTH-1,  'h99, 1'b1);
    vecs[12] = mk(2'b00, 0,      0,     0,     0,    1'b1, 2'b00, 1'b0, DEPTH-1,  'h99, 1'b0);
    vecs[13] = mk(2'b01, 'h7FFFF,0,     'h66,  0,    1'b1, 2'b01, 1'b0, DEPTH-1,  'h99, 1'b1);
    vecs[14] = mk(2'b00, 0,      0,     0,     0,    1'b1, 2'b00, 1'b0, DEPTH-1,  'h99, 1'b0);

    #12;
    chk("reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) apply_vec(vecs[i], i);

    // Full clear with requester 1 waiting throughout and a stray clear_start mid-way.
    @(negedge clk);
    req_valid = 2'b00; err_clear = 1'b0; clear_start = 1'b1; clear_color = 8'h3C;
    @(posedge clk); #1;
    chk("clear_busy_rise", 32'({clear_busy, fbuf_en_wr}), 32'b10);
    @(negedge clk);
    clear_start = 1'b0; clear_color = 8'h00;
    req_valid = 2'b10; a1 = AW'(5); d1 = 8'hEE;
    bad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk); #1;
      last = (k == DEPTH - 1);
      if (fbuf_en_wr !== 1'b1 || fbuf_wrea !== 1'b1 || fbuf_addr !== AW'(k) ||
          fbuf_data !== 8'h3C || clear_busy !== !last || clear_done !== last ||
          req_ready !== (last ? 2'b10 : 2'b00)) begin
        bad++;
      end
      clear_start = (k == 100);
    end
    chk("clear_seq_bad_cycles", 32'(bad), 32'd0);
    @(posedge clk); #1;
    chk("post_clear_write", 32'({fbuf_en_wr, clear_busy, clear_done}), 32'b100);
    chk("post_clear_addr", 32'(fbuf_addr), 32'd5);
    chk("post_clear_data", 32'(fbuf_data), 32'hEE);
    req_valid = 2'b00;
    @(posedge clk); #1;
    chk("post_clear_idle", 32'({fbuf_en_wr, clear_busy, clear_done}), 32'd0);

    // Clear start with a simultaneous accept, then reset mid-clear.
    @(negedge clk);
    clear_start = 1'b1; clear_color = 8'hC3;
    req_valid = 2'b01; a0 = AW'('h123); d0 = 8'h44;
    #1;
    chk("start_accept_ready", 32'(req_ready), 32'b01);
    @(posedge clk); #1;
    chk("start_accept_write", 32'({fbuf_en_wr, clear_busy}), 32'b11);
    chk("start_accept_addr", 32'(fbuf_addr), 32'h123);
    chk("start_accept_data", 32'(fbuf_data), 32'h44);
    req_valid = 2'b00; clear_start = 1'b0;
    found = 0;
    for (int k = 0; k < 1100 && found == 0; k++) begin
      @(posedge clk); #1;
      if (fbuf_addr == AW'(1000)) found = 1;
    end
    chk("reach_addr_1000", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_clear_immediate", all_outs(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mid_clear_held", all_outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (fbuf_en_wr !== 1'b0 || clear_done !== 1'b0 || clear_busy !== 1'b0) bad++;
    end
    chk("after_reset_quiet", 32'(bad), 32'd0);
    apply_vec(vecs[0], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
